alu_nibble_sequencer: RTL

//  Sequences one shared 4-bit ALU slice (S[2:0] op code, cin/cout) to run WIDTH-bit

---
 rtl/alu_nibble_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/alu_nibble_sequencer.sv
// Runs WIDTH-bit ALU operations nibble-serially through one shared 4-bit slice,
// least significant nibble first, and returns the result on a held response port.
module alu_nibble_sequencer #(
  parameter  int WIDTH = 16,
  localparam int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_s,
  output logic             alu_cin,
  input  logic [3:0]       alu_f,
  input  logic             alu_cout
);

  localparam int IDX_W = $clog2(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             carry_reg, carry_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [2:0]       op_reg, op_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;

  logic [3:0] a_nib [NIB];
  logic [3:0] b_nib [NIB];
  logic       accept;
  logic       in_exec;
  logic       op_arith;

  assign accept   = (state_reg == IDLE) && req_valid;
  assign in_exec  = (state_reg == EXEC);
  // Ops 001/010/011 are the only ones whose carry means anything.
  assign op_arith = (op_reg != 3'b000) && !op_reg[2];

  // Per-nibble views of the operands and per-nibble result write-back.
  generate
    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[4*gi +: 4];
      assign b_nib[gi] = b_reg[4*gi +: 4];
      assign result_next[4*gi +: 4] = (in_exec && idx_reg == IDX_W'(gi))
                                      ? alu_f : result_reg[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    carry_next = carry_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          a_next     = req_a;
          b_next     = req_b;
          op_next    = req_op;
          idx_next   = '0;
          // Subtracts are A + ~B + 1 (or B + ~A + 1), so seed the carry with 1.
          carry_next = (req_op == 3'b001) || (req_op == 3'b010);
          state_next = EXEC;
        end
      end
      EXEC: begin
        carry_next = alu_cout;
        if (idx_reg == LAST_IDX) begin
          idx_next   = '0;
          state_next = DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      carry_reg  <= 1'b0;
      result_reg <= '0;
      op_reg     <= 3'b000;
      a_reg      <= '0;
      b_reg      <= '0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      carry_reg  <= carry_next;
      result_reg <= result_next;
      op_reg     <= op_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
    end
  end

  always_comb begin
    req_ready = (state_reg == IDLE);
    rsp_valid = (state_reg == DONE);
    rsp_f     = result_reg;
    rsp_zero  = (result_reg == '0);
    rsp_cout  = (state_reg == DONE) && op_arith && carry_reg;
    alu_s     = op_reg;
    alu_a     = in_exec ? a_nib[idx_reg] : 4'h0;
    alu_b     = in_exec ? b_nib[idx_reg] : 4'h0;
    alu_cin   = in_exec ? carry_reg : 1'b0;
  end

endmodule
